// File: rtl/nrisc_pkg.sv
// Shared nRISC data-path constants and the store-buffer entry format
// used by the memory stage.
package nrisc_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;

   // Encoding of the request write-enable bit from the execute stage.
   localparam logic REQ_WE_LOAD  = 1'b0;
   localparam logic REQ_WE_STORE = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

   localparam int SB_ENTRY_W = ADDR_W + DATA_W;

endpackage

// File: rtl/mem_stage_lsu_store_buffer_fifo.sv
// Circular store buffer holding accepted stores in program order until they drain
// to memory. Exposes every slot so the load path can search for forwarding data.
module store_buffer_fifo
   import nrisc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_push,
   input  sb_entry_t                     i_push_entry,
   input  logic                          i_pop,
   output sb_entry_t                     o_head_entry,
   output logic [$clog2(DEPTH):0]        o_count,
   output logic [$clog2(DEPTH)-1:0]      o_head,
   output logic [DEPTH*SB_ENTRY_W-1:0]   o_entries
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t        r_entries [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Full/empty guards keep head, tail and count coherent even if a caller misbehaves.
   assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
   assign w_do_pop  = i_pop  && (r_count != '0);

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_entries[r_tail] <= i_push_entry;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign o_entries[g*SB_ENTRY_W +: SB_ENTRY_W] = r_entries[g];
   end

   assign o_head_entry = r_entries[r_head];
   assign o_count      = r_count;
   assign o_head       = r_head;

endmodule

// File: rtl/mem_stage_lsu.sv
// nRISC memory-stage load/store unit: owns the data memory port, buffers stores,
// gives loads priority over the drain and forwards from the youngest matching store.
module mem_stage_lsu
   import nrisc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_sb_empty,
   input  logic              i_mem_gnt,
   output logic [ADDR_W-1:0] o_mem_access_addr,
   output logic [DATA_W-1:0] o_mem_write_data,
   output logic              o_mem_write_en,
   output logic              o_mem_read,
   input  logic [DATA_W-1:0] i_mem_read_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [CNT_W-1:0]          w_count;
   logic [PTR_W-1:0]          w_head;
   sb_entry_t                 w_head_entry;
   logic [DEPTH*SB_ENTRY_W-1:0] w_entries;
   sb_entry_t                 w_push_entry;
   logic                      w_full;
   logic                      w_accept;
   logic                      w_load_acc;
   logic                      w_store_acc;
   logic                      w_drain;
   logic                      w_fwd_hit;
   logic [DATA_W-1:0]         w_fwd_data;
   logic [PTR_W-1:0]          w_fwd_idx;
   sb_entry_t                 w_fwd_entry;
   logic                      r_rsp_valid;
   logic [DATA_W-1:0]         r_rsp_rdata;

   assign w_full       = (w_count == CNT_W'(DEPTH));
   assign o_req_ready  = (i_req_we == REQ_WE_STORE) ? !w_full : i_mem_gnt;
   assign w_accept     = i_req_valid && o_req_ready;
   assign w_load_acc   = w_accept && (i_req_we == REQ_WE_LOAD);
   assign w_store_acc  = w_accept && (i_req_we == REQ_WE_STORE);
   // A load in this cycle takes the port, so the drain can never race a forwarding search.
   assign w_drain      = !w_load_acc && i_mem_gnt && (w_count != '0);
   assign w_push_entry = '{addr: i_req_addr, data: i_req_wdata};
   assign o_sb_empty   = (w_count == '0);

   store_buffer_fifo #(
      .DEPTH (DEPTH)
   ) u_store_buffer (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_push       (w_store_acc),
      .i_push_entry (w_push_entry),
      .i_pop        (w_drain),
      .o_head_entry (w_head_entry),
      .o_count      (w_count),
      .o_head       (w_head),
      .o_entries    (w_entries)
   );

   always_comb begin
      o_mem_read        = 1'b0;
      o_mem_write_en    = 1'b0;
      o_mem_access_addr = '0;
      o_mem_write_data  = '0;
      if (w_load_acc) begin
         o_mem_read        = 1'b1;
         o_mem_access_addr = i_req_addr;
      end else if (w_drain) begin
         o_mem_write_en    = 1'b1;
         o_mem_access_addr = w_head_entry.addr;
         o_mem_write_data  = w_head_entry.data;
      end
   end

   // Walk oldest to youngest so the last hit, the store nearest the tail, wins.
   always_comb begin
      w_fwd_hit   = 1'b0;
      w_fwd_data  = '0;
      w_fwd_idx   = '0;
      w_fwd_entry = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_fwd_idx   = w_head + PTR_W'(k);
         w_fwd_entry = w_entries[int'(w_fwd_idx)*SB_ENTRY_W +: SB_ENTRY_W];
         if ((CNT_W'(k) < w_count) && (w_fwd_entry.addr == i_req_addr)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = w_fwd_entry.data;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_load_acc;
         if (w_load_acc) begin
            r_rsp_rdata <= w_fwd_hit ? w_fwd_data : i_mem_read_data;
         end
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_stage_lsu;

   localparam int DEPTH = 4;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
   } st_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [7:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       sb_empty;
   logic       mem_gnt = 1'b0;
   logic [7:0] mem_access_addr;
   logic [7:0] mem_write_data;
   logic       mem_write_en;
   logic       mem_read;
   logic [7:0] mem_read_data;

   logic [7:0] env_mem [256];
   logic [7:0] ref_mem [256];
   st_t        sbq [$];
   logic       m_rsp_valid = 1'b0;
   logic [7:0] m_rsp_rdata = '0;
   bit         check_en = 1'b0;
   int         total = 0;
   int         bad = 0;

   logic       mdl_ld, mdl_dr, mdl_st;
   logic [7:0] mdl_v;
   logic       e_ready, e_ld, e_dr;
   logic [7:0] e_addr, e_wdata;

   mem_stage_lsu #(.DEPTH(DEPTH)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_req_valid       (req_valid),
      .o_req_ready       (req_ready),
      .i_req_we          (req_we),
      .i_req_addr        (req_addr),
      .i_req_wdata       (req_wdata),
      .o_rsp_valid       (rsp_valid),
      .o_rsp_rdata       (rsp_rdata),
      .o_sb_empty        (sb_empty),
      .i_mem_gnt         (mem_gnt),
      .o_mem_access_addr (mem_access_addr),
      .o_mem_write_data  (mem_write_data),
      .o_mem_write_en    (mem_write_en),
      .o_mem_read        (mem_read),
      .i_mem_read_data   (mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = env_mem[mem_access_addr];

   always @(posedge clk) begin
      if (mem_write_en) env_mem[mem_access_addr] <= mem_write_data;
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: the store buffer is a plain queue, memory a plain array.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sbq.delete();
         m_rsp_valid = 1'b0;
         m_rsp_rdata = '0;
      end else begin
         mdl_ld = req_valid && !req_we && mem_gnt;
         mdl_st = req_valid && req_we && (sbq.size() < DEPTH);
         mdl_dr = !mdl_ld && mem_gnt && (sbq.size() != 0);
         m_rsp_valid = mdl_ld;
         if (mdl_ld) begin
            mdl_v = ref_mem[req_addr];
            foreach (sbq[k]) if (sbq[k].a == req_addr) mdl_v = sbq[k].d;
            m_rsp_rdata = mdl_v;
         end
         if (mdl_dr) begin
            ref_mem[sbq[0].a] = sbq[0].d;
            void'(sbq.pop_front());
         end
         if (mdl_st) sbq.push_back('{a: req_addr, d: req_wdata});
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         e_ready = req_we ? (sbq.size() != DEPTH) : mem_gnt;
         e_ld    = req_valid && !req_we && mem_gnt;
         e_dr    = !e_ld && mem_gnt && (sbq.size() != 0);
         e_addr  = e_ld ? req_addr : (e_dr ? sbq[0].a : 8'h00);
         e_wdata = e_dr ? sbq[0].d : 8'h00;
         checkOutput("mdl_req_ready", 16'(req_ready), 16'(e_ready));
         checkOutput("mdl_mem_read", 16'(mem_read), 16'(e_ld));
         checkOutput("mdl_mem_write_en", 16'(mem_write_en), 16'(e_dr));
         checkOutput("mdl_mem_addr", 16'(mem_access_addr), 16'(e_addr));
         if (e_dr) checkOutput("mdl_mem_wdata", 16'(mem_write_data), 16'(e_wdata));
         checkOutput("mdl_sb_empty", 16'(sb_empty), 16'(sbq.size() == 0));
         checkOutput("mdl_rsp_valid", 16'(rsp_valid), 16'(m_rsp_valid));
         checkOutput("mdl_rsp_rdata", 16'(rsp_rdata), 16'(m_rsp_rdata));
      end
   end

   task automatic applyStimulus(input logic v, input logic we, input logic [7:0] a,
                                input logic [7:0] d, input logic g);
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      mem_gnt   = g;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      env_mem[8'h30] = 8'h5A;
      ref_mem[8'h30] = 8'h5A;

      rst_n = 1'b0;
      step();
      step();
      checkOutput("reset_sb_empty", 16'(sb_empty), 16'h1);
      checkOutput("reset_rsp_valid", 16'(rsp_valid), 16'h0);
      checkOutput("reset_rsp_rdata", 16'(rsp_rdata), 16'h0);
      rst_n = 1'b1;
      check_en = 1'b1;

      // Reset with two stores buffered and the port withheld.
      applyStimulus(1, 1, 8'h50, 8'h01, 0);
      step();
      applyStimulus(1, 1, 8'h51, 8'h02, 0);
      step();
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      checkOutput("pre_reset_sb_empty", 16'(sb_empty), 16'h0);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_sb_empty", 16'(sb_empty), 16'h1);
      checkOutput("midreset_rsp_valid", 16'(rsp_valid), 16'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 0, 8'h00, 8'h00, 1);
         checkOutput("post_reset_no_write", 16'(mem_write_en), 16'h0);
         step();
      end

      // Single store drains in the next idle cycle.
      applyStimulus(1, 1, 8'h10, 8'hAB, 1);
      checkOutput("store_cycle_no_write", 16'(mem_write_en), 16'h0);
      step();
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      checkOutput("drain_we", 16'(mem_write_en), 16'h1);
      checkOutput("drain_addr", 16'(mem_access_addr), 16'h10);
      checkOutput("drain_data", 16'(mem_write_data), 16'hAB);
      step();
      checkOutput("drain_empty", 16'(sb_empty), 16'h1);

      // Youngest of two same-address stores is forwarded.
      applyStimulus(1, 1, 8'h20, 8'h11, 0);
      step();
      applyStimulus(1, 1, 8'h20, 8'h22, 0);
      step();
      applyStimulus(1, 0, 8'h20, 8'h00, 1);
      checkOutput("fwd_load_ready", 16'(req_ready), 16'h1);
      checkOutput("fwd_mem_read", 16'(mem_read), 16'h1);
      checkOutput("fwd_no_write", 16'(mem_write_en), 16'h0);
      step();
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      checkOutput("fwd_rsp_valid", 16'(rsp_valid), 16'h1);
      checkOutput("fwd_rsp_rdata", 16'(rsp_rdata), 16'h22);
      step();
      step();
      checkOutput("fwd_mem_final", 16'(env_mem[8'h20]), 16'h22);

      // Load misses, back to back.
      applyStimulus(1, 0, 8'h30, 8'h00, 1);
      checkOutput("miss_no_write", 16'(mem_write_en), 16'h0);
      step();
      applyStimulus(1, 0, 8'h10, 8'h00, 1);
      checkOutput("miss_rsp_valid", 16'(rsp_valid), 16'h1);
      checkOutput("miss_rsp_rdata", 16'(rsp_rdata), 16'h5A);
      step();
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      checkOutput("b2b_rsp_valid", 16'(rsp_valid), 16'h1);
      checkOutput("b2b_rsp_rdata", 16'(rsp_rdata), 16'hAB);
      step();
      checkOutput("rsp_pulse_end", 16'(rsp_valid), 16'h0);

      // Full buffer stalls the fifth store until after the first drain.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 8'(8'h40 + i), 8'(8'hC0 + i), 0);
         checkOutput("fill_ready", 16'(req_ready), 16'h1);
         step();
      end
      applyStimulus(1, 1, 8'h44, 8'hC4, 0);
      checkOutput("full_ready", 16'(req_ready), 16'h0);
      step();
      applyStimulus(1, 1, 8'h44, 8'hC4, 1);
      checkOutput("full_drain_ready", 16'(req_ready), 16'h0);
      checkOutput("full_drain0_addr", 16'(mem_access_addr), 16'h40);
      checkOutput("full_drain0_data", 16'(mem_write_data), 16'hC0);
      step();
      applyStimulus(1, 1, 8'h44, 8'hC4, 1);
      checkOutput("full_accept_ready", 16'(req_ready), 16'h1);
      checkOutput("full_drain1_addr", 16'(mem_access_addr), 16'h41);
      step();
      for (int j = 2; j < 5; j++) begin
         applyStimulus(0, 0, 8'h00, 8'h00, 1);
         checkOutput("full_drain_we", 16'(mem_write_en), 16'h1);
         checkOutput("full_drain_addr", 16'(mem_access_addr), 16'(8'h40 + j));
         checkOutput("full_drain_data", 16'(mem_write_data), 16'(8'hC0 + j));
         step();
      end
      checkOutput("full_empty", 16'(sb_empty), 16'h1);

      // Loads hold off the drain; drain resumes on the first idle cycle.
      applyStimulus(1, 1, 8'h60, 8'h66, 0);
      step();
      applyStimulus(1, 1, 8'h61, 8'h77, 0);
      step();
      applyStimulus(1, 0, 8'h30, 8'h00, 1);
      checkOutput("prio_no_write0", 16'(mem_write_en), 16'h0);
      step();
      applyStimulus(1, 0, 8'h61, 8'h00, 1);
      checkOutput("prio_no_write1", 16'(mem_write_en), 16'h0);
      checkOutput("prio_rsp0", 16'(rsp_rdata), 16'h5A);
      step();
      applyStimulus(1, 0, 8'h60, 8'h00, 1);
      checkOutput("prio_no_write2", 16'(mem_write_en), 16'h0);
      checkOutput("prio_rsp1", 16'(rsp_rdata), 16'h77);
      step();
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      checkOutput("prio_rsp2", 16'(rsp_rdata), 16'h66);
      checkOutput("prio_resume_we", 16'(mem_write_en), 16'h1);
      checkOutput("prio_resume_addr", 16'(mem_access_addr), 16'h60);
      step();
      checkOutput("prio_second_addr", 16'(mem_access_addr), 16'h61);
      step();
      checkOutput("prio_empty", 16'(sb_empty), 16'h1);
      checkOutput("prio_mem_61", 16'(env_mem[8'h61]), 16'h77);

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
